dct_mac_pipe: RTL and testbench

- Parametrised pipelined multiply-accumulate unit for the FDCT datapath. Successor to the single-width macu with its enable-qualified mult_res register.
- Registers sample and coefficient, registers the product (enable-gated), and accumulates TERMS products per block.
- Rounds, shifts and saturates the sum to OWIDTH, then emits a one-cycle result strobe.
- Instantiated once per DCT unit inside each dct_block; the global ena stalls the whole pipeline.

---
 rtl/dct_mac_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_dct_mac_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dct_mac_pipe.sv
// dct_mac_pipe: pipelined signed multiply-accumulate for the FDCT datapath.
// Registers sample and coefficient, forms the full-width product, and
// accumulates TERMS products per block. The finished sum is rounded
// half-up, shifted right by SHIFT and saturated (or wrapped) to OWIDTH.
// A one-cycle dout_valid strobe marks each result. A one-cycle abort
// strobe marks a block that was restarted early or a stray term that was
// dropped. The global ena input freezes every register in the pipeline.
module dct_mac_pipe #(
   parameter int DWIDTH = 8,
   parameter int CWIDTH = 12,
   parameter int TERMS  = 8,
   parameter int AWIDTH = DWIDTH + CWIDTH + $clog2(TERMS),
   parameter int SHIFT  = 4,
   parameter int OWIDTH = 12,
   parameter int SAT    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic                     in_valid,
   input  logic                     first,
   input  logic signed [DWIDTH-1:0] din,
   input  logic signed [CWIDTH-1:0] coef,
   output logic signed [OWIDTH-1:0] dout,
   output logic                     dout_valid,
   output logic                     ovf,
   output logic                     abort
);

   localparam int PWIDTH = DWIDTH + CWIDTH;
   localparam int CNTW   = $clog2(TERMS + 1);

   localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
   localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TERMS - 1);

   // Rounding constant 2^(SHIFT-1) at the widened rounding width.
   localparam logic signed [AWIDTH:0] HALF = (AWIDTH + 1)'(1) << (SHIFT - 1);
   // Output range limits, sign-extended to the rounding width.
   localparam logic signed [AWIDTH:0] OMAX =
      {{(AWIDTH + 2 - OWIDTH){1'b0}}, {(OWIDTH - 1){1'b1}}};
   localparam logic signed [AWIDTH:0] OMIN =
      {{(AWIDTH + 2 - OWIDTH){1'b1}}, {(OWIDTH - 1){1'b0}}};

   // Sign-extend a product to accumulator width.
   function automatic logic signed [AWIDTH-1:0] sext_prod(
      input logic signed [PWIDTH-1:0] p
   );
      return {{(AWIDTH - PWIDTH){p[PWIDTH-1]}}, p};
   endfunction

   // Full signed product of sample and coefficient at PWIDTH bits.
   function automatic logic signed [PWIDTH-1:0] mul_full(
      input logic signed [DWIDTH-1:0] a,
      input logic signed [CWIDTH-1:0] b
   );
      logic signed [PWIDTH-1:0] a_x;
      logic signed [PWIDTH-1:0] b_x;
      a_x = {{CWIDTH{a[DWIDTH-1]}}, a};
      b_x = {{DWIDTH{b[CWIDTH-1]}}, b};
      return a_x * b_x;
   endfunction

   // Stage 1: input capture
   logic signed [DWIDTH-1:0] din_d,  din_q;
   logic signed [CWIDTH-1:0] coef_d, coef_q;
   logic                     v1_d,   v1_q;
   logic                     f1_d,   f1_q;
   // Stage 2: product
   logic signed [PWIDTH-1:0] mult_d, mult_q;
   logic                     v2_d,   v2_q;
   logic                     f2_d,   f2_q;
   // Stage 3: accumulator and term counter
   logic signed [AWIDTH-1:0] acc_d,  acc_q;
   logic [CNTW-1:0]          cnt_d,  cnt_q;
   logic                     done3_d, done3_q;
   logic                     abort3_d, abort3_q;
   // Stage 4: rounding add
   logic signed [AWIDTH:0]   rnd_d,  rnd_q;
   logic                     done4_d, done4_q;
   logic                     abort4_d, abort4_q;
   // Stage 5: shift, saturate, output registers
   logic signed [OWIDTH-1:0] dout_d, dout_q;
   logic                     ovf_d,  ovf_q;
   logic                     dout_valid_d, dout_valid_q;
   logic                     abort_d, abort_q;
   logic signed [AWIDTH:0]   shifted_s;

   // Next-state logic for every pipeline stage.
   always_comb begin
      // Stage 1: first is only meaningful together with in_valid.
      din_d  = din;
      coef_d = coef;
      v1_d   = in_valid;
      f1_d   = in_valid & first;

      // Stage 2: only update the product on valid slots to save toggling.
      if (v1_q) begin
         mult_d = mul_full(din_q, coef_q);
      end else begin
         mult_d = mult_q;
      end
      v2_d = v1_q;
      f2_d = f1_q;

      // Stage 3: accumulate, count terms, flag completion or abort.
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      done3_d  = 1'b0;
      abort3_d = 1'b0;
      if (f2_q) begin
         // A new block starts here. A non-zero count means a partial
         // block is being thrown away.
         if (cnt_q != CNT_ZERO) begin
            abort3_d = 1'b1;
         end else begin
            abort3_d = 1'b0;
         end
         acc_d = sext_prod(mult_q);
         cnt_d = CNT_ONE;
      end else if (v2_q) begin
         if (cnt_q == CNT_ZERO) begin
            // A term with no open block is dropped.
            abort3_d = 1'b1;
         end else begin
            acc_d = acc_q + sext_prod(mult_q);
            if (cnt_q == CNT_LAST) begin
               cnt_d   = CNT_ZERO;
               done3_d = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
      end else begin
         // Bubble: accumulator and counter hold.
         acc_d = acc_q;
         cnt_d = cnt_q;
      end

      // Stage 4: add the half-LSB. acc_q still holds the finished sum
      // here, even if a new block overwrites it on this same edge.
      if (done3_q) begin
         rnd_d = {acc_q[AWIDTH-1], acc_q} + HALF;
      end else begin
         rnd_d = rnd_q;
      end
      done4_d  = done3_q;
      abort4_d = abort3_q;

      // Stage 5: arithmetic shift, then range-limit to OWIDTH.
      shifted_s = rnd_q >>> SHIFT;
      dout_d    = dout_q;
      ovf_d     = ovf_q;
      if (done4_q) begin
         if (shifted_s > OMAX) begin
            ovf_d  = 1'b1;
            dout_d = (SAT != 0) ? OMAX[OWIDTH-1:0] : shifted_s[OWIDTH-1:0];
         end else if (shifted_s < OMIN) begin
            ovf_d  = 1'b1;
            dout_d = (SAT != 0) ? OMIN[OWIDTH-1:0] : shifted_s[OWIDTH-1:0];
         end else begin
            ovf_d  = 1'b0;
            dout_d = shifted_s[OWIDTH-1:0];
         end
      end else begin
         dout_d = dout_q;
         ovf_d  = ovf_q;
      end
      dout_valid_d = done4_q;
      abort_d      = abort4_q;
   end

   // Pipeline registers: async clear, advance only on ena.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         din_q        <= {DWIDTH{1'b0}};
         coef_q       <= {CWIDTH{1'b0}};
         v1_q         <= 1'b0;
         f1_q         <= 1'b0;
         mult_q       <= {PWIDTH{1'b0}};
         v2_q         <= 1'b0;
         f2_q         <= 1'b0;
         acc_q        <= {AWIDTH{1'b0}};
         cnt_q        <= CNT_ZERO;
         done3_q      <= 1'b0;
         abort3_q     <= 1'b0;
         rnd_q        <= {(AWIDTH + 1){1'b0}};
         done4_q      <= 1'b0;
         abort4_q     <= 1'b0;
         dout_q       <= {OWIDTH{1'b0}};
         ovf_q        <= 1'b0;
         dout_valid_q <= 1'b0;
         abort_q      <= 1'b0;
      end else if (ena) begin
         din_q        <= din_d;
         coef_q       <= coef_d;
         v1_q         <= v1_d;
         f1_q         <= f1_d;
         mult_q       <= mult_d;
         v2_q         <= v2_d;
         f2_q         <= f2_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         done3_q      <= done3_d;
         abort3_q     <= abort3_d;
         rnd_q        <= rnd_d;
         done4_q      <= done4_d;
         abort4_q     <= abort4_d;
         dout_q       <= dout_d;
         ovf_q        <= ovf_d;
         dout_valid_q <= dout_valid_d;
         abort_q      <= abort_d;
      end
   end

   assign dout       = dout_q;
   assign ovf        = ovf_q;
   assign dout_valid = dout_valid_q;
   assign abort      = abort_q;

endmodule

// File: tb/tb_dct_mac_pipe.sv
// Testbench for dct_mac_pipe (default parameters). Every output is
// predicted by a block-level model that tracks open terms, the running sum
// and a queue of pending results/aborts due 4 enabled edges after the term.
module tb_dct_mac_pipe;

   logic                clk;
   logic                rst;
   logic                ena;
   logic                in_valid;
   logic                first;
   logic signed [7:0]   din;
   logic signed [11:0]  coef;
   logic signed [11:0]  dout;
   logic                dout_valid;
   logic                ovf;
   logic                abort;

   dct_mac_pipe dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .in_valid   (in_valid),
      .first      (first),
      .din        (din),
      .coef       (coef),
      .dout       (dout),
      .dout_valid (dout_valid),
      .ovf        (ovf),
      .abort      (abort)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int                 due;
      bit                 is_abort;
      logic signed [11:0] val;
      bit                 ov;
   } ev_t;

   ev_t                q[$];
   int                 n_tests = 0;
   int                 n_fail  = 0;
   int                 ena_edges = 0;
   int                 blk_n = 0;
   longint             blk_sum = 0;
   bit                 exp_dv = 1'b0;
   bit                 exp_ab = 1'b0;
   logic signed [11:0] exp_dout = 12'sd0;
   bit                 exp_ovf = 1'b0;

   // Single comparison point.
   task automatic chk(input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string ctx);
      chk({ctx, ".dout_valid"}, int'(dout_valid), int'(exp_dv));
      chk({ctx, ".abort"},      int'(abort),      int'(exp_ab));
      chk({ctx, ".dout"},       int'(dout),       int'(exp_dout));
      chk({ctx, ".ovf"},        int'(ovf),        int'(exp_ovf));
   endtask

   task automatic push_abort();
      ev_t e;
      e.due = ena_edges + 4; e.is_abort = 1'b1; e.val = 12'sd0; e.ov = 1'b0;
      q.push_back(e);
   endtask

   // Round half up, shift by 4, clamp to 12-bit signed range.
   task automatic push_result(input longint sum);
      ev_t    e;
      longint r;
      r = (sum + 64'sd8) >>> 4;
      e.due = ena_edges + 4; e.is_abort = 1'b0;
      if (r > 64'sd2047) begin
         e.val = 12'sd2047;  e.ov = 1'b1;
      end else if (r < -64'sd2048) begin
         e.val = -12'sd2048; e.ov = 1'b1;
      end else begin
         e.val = 12'(r);     e.ov = 1'b0;
      end
      q.push_back(e);
   endtask

   // One clock: drive inputs, advance the model on enabled edges, check.
   task automatic step(input bit e, input bit v, input bit f,
                       input logic [7:0] d, input logic [11:0] c);
      longint p;
      ena = e; in_valid = v; first = f; din = d; coef = c;
      @(posedge clk);
      if (e) begin
         ena_edges++;
         if (v) begin
            p = longint'($signed(d)) * longint'($signed(c));
            if (f) begin
               if (blk_n > 0) push_abort();
               blk_n = 1; blk_sum = p;
            end else if (blk_n == 0) begin
               push_abort();
            end else begin
               blk_sum += p; blk_n++;
               if (blk_n == 8) begin
                  push_result(blk_sum);
                  blk_n = 0;
               end
            end
         end
         exp_dv = 1'b0; exp_ab = 1'b0;
         if (q.size() > 0 && q[0].due == ena_edges) begin
            if (q[0].is_abort) begin
               exp_ab = 1'b1;
            end else begin
               exp_dv = 1'b1; exp_dout = q[0].val; exp_ovf = q[0].ov;
            end
            void'(q.pop_front());
         end
      end
      #1;
      check_outputs("step");
   endtask

   task automatic block8(input logic [7:0] d, input logic [11:0] c);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, (i == 0), d, c);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'd0, 12'd0);
   endtask

   task automatic expect_result(input string tag, input int val, input int ov);
      chk({tag, ".last_dout"}, int'(dout), val);
      chk({tag, ".last_ovf"},  int'(ovf),  ov);
   endtask

   initial begin
      rst = 1'b0; ena = 1'b0; in_valid = 1'b0; first = 1'b0;
      din = 8'sd0; coef = 12'sd0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst = 1'b1;
      idle(2);

      // Basic block: 8 x (10*16) = 1280 -> 80.
      block8(8'd10, 12'd16);
      idle(5);
      expect_result("basic", 80, 0);

      // Small positive and negative sums exercising rounding.
      block8(8'd3, 12'd1);
      idle(5);
      expect_result("round_pos", 2, 0);
      block8(-8'sd3, 12'd1);
      idle(5);
      expect_result("round_neg", -1, 0);

      // Saturation at both ends.
      block8(8'sd127, 12'sd2047);
      idle(5);
      expect_result("sat_hi", 2047, 1);
      block8(-8'sd128, 12'sd2047);
      idle(5);
      expect_result("sat_lo", -2048, 1);

      // Stalls and bubbles within one block: sum 128 -> 8.
      step(1'b1, 1'b1, 1'b1, 8'd1, 12'd16);
      step(1'b1, 1'b1, 1'b0, 8'd1, 12'd16);
      step(1'b1, 1'b0, 1'b0, 8'd0, 12'd0);
      step(1'b1, 1'b1, 1'b0, 8'd1, 12'd16);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'd55, 12'd99);
      step(1'b1, 1'b1, 1'b0, 8'd1, 12'd16);
      step(1'b1, 1'b0, 1'b0, 8'd0, 12'd0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'd1, 12'd16);
      step(1'b1, 1'b0, 1'b0, 8'd0, 12'd0);
      step(1'b1, 1'b0, 1'b0, 8'd0, 12'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 12'd0);
      idle(4);
      expect_result("stall", 8, 0);

      // Restart after 5 terms, then a full block; then a stray term.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, (i == 0), 8'd7, 12'd9);
      block8(8'd2, 12'd8);
      idle(5);
      expect_result("restart", 8, 0);
      step(1'b1, 1'b1, 1'b0, 8'd50, 12'd50);
      idle(5);

      // Asynchronous reset in the middle of a block.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, (i == 0), 8'd10, 12'd16);
      #2;
      rst = 1'b0;
      #1;
      q.delete(); blk_n = 0; blk_sum = 0;
      exp_dv = 1'b0; exp_ab = 1'b0; exp_dout = 12'sd0; exp_ovf = 1'b0;
      check_outputs("async_rst");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle(2);
      block8(8'd10, 12'd16);
      idle(5);
      expect_result("after_rst", 80, 0);

      // Randomised traffic with stalls, bubbles, restarts and stray terms.
      for (int i = 0; i < 400; i++) begin
         bit e, v, f;
         e = ($urandom_range(0, 7) != 0);
         v = ($urandom_range(0, 3) != 0);
         if (blk_n == 0) f = ($urandom_range(0, 9) != 0);
         else            f = ($urandom_range(0, 19) == 0);
         step(e, v, f, 8'($urandom), 12'($urandom));
      end
      idle(6);
      chk("pending_events", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
